// File: rtl/btn_input_conditioner_pkg.sv
// Shared button-conditioner definitions: one-hot FSM encoding
// and the board-rate default debounce/hold/repeat counts.
package btn_input_conditioner_pkg;

  localparam int unsigned DEF_DBNC_CNT   = 1_000_000;
  localparam int unsigned DEF_HOLD_CNT   = 50_000_000;
  localparam int unsigned DEF_REPEAT_CNT = 25_000_000;

  localparam int S_INI  = 0;
  localparam int S_WQ   = 1;
  localparam int S_SCEN = 2;
  localparam int S_HOLD = 3;
  localparam int S_MCEN = 4;
  localparam int S_RPT  = 5;
  localparam int S_WFR  = 6;

  typedef enum logic [6:0] {
    INI     = 7'b000_0001,
    WQ      = 7'b000_0010,
    SCEN_ST = 7'b000_0100,
    HOLD    = 7'b000_1000,
    MCEN_ST = 7'b001_0000,
    RPT     = 7'b010_0000,
    WFR     = 7'b100_0000
  } btn_state_e;

endpackage

// File: rtl/btn_input_conditioner_debounce_fsm.sv
// One button: 2-flop synchronizer, one-hot debounce/auto-repeat
// FSM with a shared cycle counter, Moore-decoded outputs.
module btn_debounce_fsm
  import btn_input_conditioner_pkg::*;
#(
  parameter int DBNC_CNT   = DEF_DBNC_CNT,
  parameter int HOLD_CNT   = DEF_HOLD_CNT,
  parameter int REPEAT_CNT = DEF_REPEAT_CNT,
  parameter int CNT_W      = $clog2(HOLD_CNT)
) (
  input  logic Clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_db,
  output logic btn_scen,
  output logic btn_mcen
);

  localparam logic [CNT_W-1:0] DBNC_TC = CNT_W'(DBNC_CNT - 1);
  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CNT - 1);
  localparam logic [CNT_W-1:0] RPT_TC  = CNT_W'(REPEAT_CNT - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_inc;
  logic             cnt_clr;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= INI;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    s1_d    = btn_raw;
    s2_d    = s1_q;
    state_d = state_q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    unique case (1'b1)
      state_q[S_INI]: begin
        if (s2_q) state_d = WQ;
      end
      state_q[S_WQ]: begin
        if (!s2_q)                 state_d = INI;
        else if (cnt_q == DBNC_TC) state_d = SCEN_ST;
        else                       cnt_inc = 1'b1;
      end
      state_q[S_SCEN]: begin
        state_d = HOLD;
      end
      state_q[S_HOLD]: begin
        if (!s2_q)                 state_d = WFR;
        else if (cnt_q == HOLD_TC) state_d = MCEN_ST;
        else                       cnt_inc = 1'b1;
      end
      state_q[S_MCEN]: begin
        state_d = RPT;
      end
      state_q[S_RPT]: begin
        if (!s2_q)                state_d = WFR;
        else if (cnt_q == RPT_TC) state_d = MCEN_ST;
        else                      cnt_inc = 1'b1;
      end
      state_q[S_WFR]: begin
        // bounce while releasing only restarts the release timer
        if (s2_q)                  cnt_clr = 1'b1;
        else if (cnt_q == DBNC_TC) state_d = INI;
        else                       cnt_inc = 1'b1;
      end
      default: begin
        state_d = INI;
      end
    endcase
    if (state_d != state_q || cnt_clr) cnt_d = '0;
    else if (cnt_inc)                   cnt_d = cnt_q + 1'b1;
    else                                cnt_d = cnt_q;
  end

  assign btn_scen = state_q[S_SCEN];
  assign btn_mcen = state_q[S_SCEN] | state_q[S_MCEN];
  assign btn_db   = ~(state_q[S_INI] | state_q[S_WQ]);

endmodule

// File: rtl/btn_input_conditioner.sv
// Board-pin button conditioner: one independent debounce FSM
// per button, bused out to the game core.
module btn_input_conditioner
  import btn_input_conditioner_pkg::*;
#(
  parameter int NUM_BTNS   = 5,
  parameter int DBNC_CNT   = DEF_DBNC_CNT,
  parameter int HOLD_CNT   = DEF_HOLD_CNT,
  parameter int REPEAT_CNT = DEF_REPEAT_CNT,
  parameter int CNT_W      = $clog2(HOLD_CNT)
) (
  input  logic                Clk,
  input  logic                reset_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_db,
  output logic [NUM_BTNS-1:0] btn_scen,
  output logic [NUM_BTNS-1:0] btn_mcen
);

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce_fsm #(
      .DBNC_CNT   (DBNC_CNT),
      .HOLD_CNT   (HOLD_CNT),
      .REPEAT_CNT (REPEAT_CNT),
      .CNT_W      (CNT_W)
    ) u_fsm (
      .Clk      (Clk),
      .reset_n  (reset_n),
      .btn_raw  (btn_raw[i]),
      .btn_db   (btn_db[i]),
      .btn_scen (btn_scen[i]),
      .btn_mcen (btn_mcen[i])
    );
  end

endmodule

// File: tb/tb_btn_input_conditioner.sv
// Scoreboard bench for btn_input_conditioner with short counts
// (DBNC=4, HOLD=10, REPEAT=5); edge 1 = first edge sampling a 1.
module tb_btn_input_conditioner;

  logic       Clk;
  logic       reset_n;
  logic [4:0] btn_raw;
  logic [4:0] btn_db;
  logic [4:0] btn_scen;
  logic [4:0] btn_mcen;

  typedef struct packed {
    logic [4:0] db;
    logic [4:0] sc;
    logic [4:0] mc;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;
  int   ecnt;

  btn_input_conditioner #(
    .NUM_BTNS   (5),
    .DBNC_CNT   (4),
    .HOLD_CNT   (10),
    .REPEAT_CNT (5)
  ) dut (
    .Clk      (Clk),
    .reset_n  (reset_n),
    .btn_raw  (btn_raw),
    .btn_db   (btn_db),
    .btn_scen (btn_scen),
    .btn_mcen (btn_mcen)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s edge %0d: got %0h want %0h",
               tag, ecnt, obs, exp);
    end
  endtask

  task automatic step(input logic [4:0] raw,
                      input logic [4:0] xdb,
                      input logic [4:0] xsc,
                      input logic [4:0] xmc);
    exp_t e;
    btn_raw = raw;
    sb.push_back('{db: xdb, sc: xsc, mc: xmc});
    @(posedge Clk);
    #1;
    ecnt++;
    e = sb.pop_front();
    chk("db",   32'(btn_db),   32'(e.db));
    chk("scen", 32'(btn_scen), 32'(e.sc));
    chk("mcen", 32'(btn_mcen), 32'(e.mc));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_db"},   32'(btn_db),   32'd0);
    chk({tag, "_scen"}, 32'(btn_scen), 32'd0);
    chk({tag, "_mcen"}, 32'(btn_mcen), 32'd0);
  endtask

  initial begin
    logic r, d, s, m, r0;
    n_vec   = 0;
    n_err   = 0;
    ecnt    = 0;
    reset_n = 1'b0;
    btn_raw = '0;
    #12;
    chk_zero("reset");
    reset_n = 1'b1;
    for (int e = 1; e <= 4; e++) step('0, '0, '0, '0);

    // short press glitch: nothing happens
    ecnt = 0;
    for (int e = 1; e <= 10; e++) begin
      r = (e <= 3);
      step({4'b0, r}, '0, '0, '0);
    end

    // long press: press, hold, two repeats, release
    ecnt = 0;
    for (int e = 1; e <= 45; e++) begin
      r = (e <= 30);
      d = (e >= 7) && (e < 37);
      s = (e == 7);
      m = (e == 7) || (e == 18) || (e == 24) || (e == 30);
      step({4'b0, r}, {4'b0, d}, {4'b0, s}, {4'b0, m});
    end

    // press bounce, stable hold, release bounce
    ecnt = 0;
    for (int e = 1; e <= 50; e++) begin
      if (e <= 8)       r = (e % 2 == 1);
      else if (e <= 28) r = 1'b1;
      else if (e <= 34) r = (e % 2 == 0);
      else              r = 1'b0;
      d = (e >= 15) && (e <= 39);
      s = (e == 15);
      m = (e == 15) || (e == 26);
      step({3'b0, r, 1'b0}, {3'b0, d, 1'b0},
           {3'b0, s, 1'b0}, {3'b0, m, 1'b0});
    end

    // two buttons together, released mid-HOLD
    ecnt = 0;
    for (int e = 1; e <= 30; e++) begin
      r = (e <= 15);
      d = (e >= 7) && (e <= 21);
      s = (e == 7);
      step({2'b0, r, 1'b0, r}, {2'b0, d, 1'b0, d},
           {2'b0, s, 1'b0, s}, {2'b0, s, 1'b0, s});
    end

    // reach RPT, then async reset mid-cycle
    ecnt = 0;
    for (int e = 1; e <= 21; e++) begin
      d = (e >= 7);
      s = (e == 7);
      m = (e == 7) || (e == 18);
      step({1'b0, 1'b1, 3'b0}, {1'b0, d, 3'b0},
           {1'b0, s, 3'b0}, {1'b0, m, 3'b0});
    end
    #3;
    reset_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge Clk);
    #1;
    chk_zero("in_rst");
    #3;
    reset_n = 1'b1;

    // raw still held: fresh press, then release from RPT
    ecnt = 0;
    for (int e = 1; e <= 30; e++) begin
      r0 = (e <= 19);
      d = (e >= 7) && (e <= 25);
      s = (e == 7);
      m = (e == 7) || (e == 18);
      step({1'b0, r0, 3'b0}, {1'b0, d, 3'b0},
           {1'b0, s, 3'b0}, {1'b0, m, 3'b0});
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
